tff_bank: RTL

TFF_BANK -- requirements
Module: tff_bank

---
 rtl/tff_pkg.sv | 10 +
 rtl/tff_cell.sv | 24 ++
 rtl/tff_bank.sv | 96 +++++++++
 3 files changed

// File: rtl/tff_pkg.sv
// Shared encodings for the T flip-flop bank.
package tff_pkg;

  // Operating modes sampled on every rising edge.
  localparam logic [1:0] TFF_TOGGLE = 2'b00;
  localparam logic [1:0] TFF_UP     = 2'b01;
  localparam logic [1:0] TFF_DOWN   = 2'b10;
  localparam logic [1:0] TFF_HOLD   = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// One T flip-flop bit with synchronous active-low reset and synchronous load.
module tff_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);

  logic r_q;

  // Reset beats load, load beats toggle.
  always_ff @(posedge clk) begin
    if (!rstn)     r_q <= RESET_VAL;
    else if (load) r_q <= d;
    else if (t)    r_q <= ~r_q;
  end

  assign q = r_q;

endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops acting as a toggle register or an up/down
// counter, with a one-cycle terminal-count pulse and a sticky overflow flag.
module tff_bank
  import tff_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter bit                 WRAP      = 1'b1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_carry;   // w_carry[i]  = &q[i-1:0]  (bit i toggles on increment)
  logic [WIDTH-1:0] w_borrow;  // w_borrow[i] = ~|q[i-1:0] (bit i toggles on decrement)
  logic [WIDTH-1:0] w_en;
  logic             w_hit;     // enabled count at terminal value this edge
  logic             r_tc;
  logic             r_ovf;

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign w_carry[gi]  = w_carry[gi-1]  &  w_q[gi-1];
      assign w_borrow[gi] = w_borrow[gi-1] & ~w_q[gi-1];
    end
  endgenerate

  // Per-bit toggle enables from mode, t and the carry/borrow chains.
  // When saturating, a terminal hit freezes every bit instead of wrapping.
  always_comb begin
    w_en  = '0;
    w_hit = 1'b0;
    case (mode)
      TFF_TOGGLE: w_en = t;
      TFF_UP: begin
        if (t[0]) begin
          w_hit = &w_q;
          w_en  = (w_hit && !WRAP) ? '0 : w_carry;
        end
      end
      TFF_DOWN: begin
        if (t[0]) begin
          w_hit = ~|w_q;
          w_en  = (w_hit && !WRAP) ? '0 : w_borrow;
        end
      end
      default: w_en = '0;
    endcase
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell #(
        .RESET_VAL (RESET_VAL[gi])
      ) u_cell (
        .clk  (clk),
        .rstn (rstn),
        .load (load),
        .d    (d[gi]),
        .t    (w_en[gi]),
        .q    (w_q[gi])
      );
    end
  endgenerate

  // Terminal-count pulse and sticky overflow; load suppresses the hit,
  // and a same-edge set wins over clr_ovf.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_tc <= w_hit && !load;
      if (w_hit && !load) r_ovf <= 1'b1;
      else if (clr_ovf)   r_ovf <= 1'b0;
    end
  end

  assign q   = w_q;
  assign tc  = r_tc;
  assign ovf = r_ovf;

endmodule
